yarp_ctrl_pipe: RTL and testbench
=================================

# yarp_ctrl_pipe

Parametrised pipelined control unit for the YARP core. It decodes the instruction-type flags and the opcode/funct fields into one control word, then carries that word through a configurable number of stage registers. Each consumer (EX, MEM, WB) reads from its own tap, and every word carries a valid bit so stall, flush and bubble handling are exact. The block replaces the fixed-depth control unit, adds illegal-instruction detection, and counts retired instructions.

## Interface
Parameters:
- MEM_STAGE, 2, stage index of the MEM tap; must satisfy 2 ≤ MEM_STAGE < WB_STAGE
- WB_STAGE, 3, stage index of the WB tap (= pipeline depth N); WB_STAGE ≤ 6
- CNT_W, 32, width of the retired-instruction counter

Ports (clock and reset first):
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- id_valid_i  in  1  decode slot holds a real instruction
- is_r/i/s/b/u/j_type_i  in  1 each  one-hot instruction-type flags
- instr_funct3_i  in  3  funct3 field
- instr_funct7_bit5_i  in  1  bit 5 of funct7
- instr_opcode_i  in  7  opcode field
- stall_i  in  1  freeze every stage register
- flush_i  in  1  kill the decode slot and stage 1 (EX)
- ex_valid_o  out  1  stage-1 word is valid
- op1sel_o, op2sel_o  out  1 each  ALU operand selects (stage 1)
- alu_func_o  out  4  ALU function (stage 1)
- pc_sel_o  out  1  unconditional jump target select (stage 1), gated by valid
- data_req_o, data_wr_o  out  1 each  memory request and write (MEM tap), gated by valid
- data_byte_o  out  2  access size (MEM tap)
- zero_extnd_o  out  1  load zero-extension (MEM tap)
- rf_wr_data_o  out  2  write-back source (WB tap)
- rf_wr_en_o  out  1  register-file write enable (WB tap), gated by valid
- illegal_o  out  1  stage-1 word came from an undecodable instruction
- instret_o  out  CNT_W  count of retired instructions

## Operation
- Decode (combinational):
  - R-type: key {funct7b5, funct3} selects ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; write source Alu; rf_wr_en = 1.
  - I-type with opcode[4] = 1: ALU-immediate. op2sel = 1. SRLI and SRAI are split by funct7b5.
  - I-type with opcode[4] = 0: loads LB/LH/LW/LBU/LHU. data_req = 1, write source Mem, op2sel = 1, ALU op ADD. zero_extnd = 1 for the unsigned loads.
  - JALR (opcode 1100111): op2sel = 1, ALU op ADD, pc_sel = 1, write source Pc, rf_wr_en = 1.
  - S-type: SB/SH/SW. data_req = data_wr = 1, op2sel = 1, ALU op ADD.
  - B-type: op1sel = op2sel = 1, ALU op ADD, no write.
  - LUI (0110111): write source Imm. AUIPC (0010111): op1sel = op2sel = 1, write source Alu.
  - J-type: op1sel = op2sel = 1, pc_sel = 1, write source Pc, rf_wr_en = 1.
- Illegal instruction: no type flag set, or a funct3/opcode combination not listed above. The word enters with every side-effect field cleared and illegal = 1, so it behaves as a bubble that is flagged.
- Stage advance: word[k] ← word[k-1] and valid[k] ← valid[k-1]. Stage 1 loads the decoded word, with valid = id_valid_i & ~flush_i.
- stall_i = 1: all stages hold their contents; the decode slot is not consumed.
- flush_i = 1: valid[1] is cleared and the incoming word is dropped. Stages ≥ 2 advance normally. flush_i takes priority over stall_i: the pipeline advances that cycle.
- Side-effect outputs (pc_sel, data_req, data_wr, rf_wr_en) are ANDed with the valid bit of their stage.
- instret_o increments by 1 each non-stalled cycle in which the WB stage is valid and not illegal. It wraps modulo 2^CNT_W.

## Timing
- Reset: all valid bits, all control fields, illegal_o and instret_o are 0. Every output reads 0 on the cycle after reset is sampled low.
- Reset mid-operation discards all in-flight words. Reset dominates stall_i and flush_i.
- An instruction accepted at edge t appears at the EX tap after edge t, at the MEM tap after edge t+MEM_STAGE-1, and at the WB tap after edge t+WB_STAGE-1.
- Stall latency is 0: outputs stay constant while stall_i is high.
- The counter updates on the same edge on which the WB word leaves its stage.

## Structure
- yarp_pkg holds: the control_t struct with a valid and an illegal bit, the ALU op enum with OP_AND added, the write-source enum (Alu/Mem/Imm/Pc), the access-size enum, and the opcode constants.
- Sub-module yarp_ctrl_decode: purely combinational, produces control_t. The top level holds the stage register array (generate loop over 1..WB_STAGE), the flush/stall logic and the counter.

## Test plan
- Reset: after reset, every output and instret_o = 0; continued bubbles keep instret_o = 0.
- Fixed sequence ADD, LW, SW, JAL:
  - ADD: alu_func_o = OP_ADD at t+1, rf_wr_en_o = 1 at the WB tap.
  - LW: data_req_o = 1 and data_byte_o = Word at the MEM tap.
  - SW: data_wr_o = 1 at the MEM tap.
  - JAL: pc_sel_o = 1 at t+1.
  - Result: instret_o = 4.
- Stall stage 1 for 3 cycles: outputs frozen, no duplicate or lost words, instret_o unchanged during the stall.
- Flush together with stall on a branch: the EX word and the decode word are dropped, older words still retire, and rf_wr_en_o never pulses for the dropped words.
- Illegal funct3 on S-type: illegal_o = 1 at t+1, no data_req_o, instret_o does not increment.
- Build with MEM_STAGE = 3, WB_STAGE = 5, CNT_W = 4: tap latencies follow the formulas above, and after 17 retirements instret_o = 1 (wrapped).

Source files
------------

// File: rtl/yarp_pkg.sv
// yarp_pkg: control-word types, ALU/write-source/access-size encodings and opcodes for the YARP control path.
package yarp_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_XOR, OP_SLTU, OP_SLT
  } alu_op_t;

  typedef enum logic [1:0] {
    RF_ALU = 2'b00,
    RF_MEM = 2'b01,
    RF_IMM = 2'b10,
    RF_PC  = 2'b11
  } rf_src_t;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b11
  } mem_size_t;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_ALUI  = 7'b0010011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_J     = 7'b1101111;

  typedef struct packed {
    logic      valid;
    logic      illegal;
    logic      op1sel;
    logic      op2sel;
    alu_op_t   alu_func;
    logic      pc_sel;
    logic      data_req;
    logic      data_wr;
    mem_size_t data_byte;
    logic      zero_extnd;
    logic      rf_wr_en;
    rf_src_t   rf_wr_data;
  } control_t;

  // funct3[1:0] of loads and stores encodes the access size
  function automatic mem_size_t size_of(input logic [1:0] f);
    return f == 2'b00 ? BYTE : f == 2'b01 ? HALF : WORD;
  endfunction

endpackage

// File: rtl/yarp_ctrl_decode.sv
// yarp_ctrl_decode: combinational decode of type flags and opcode/funct fields into one control word.
module yarp_ctrl_decode
  import yarp_pkg::*;
(
  input  logic       is_r_type_i,
  input  logic       is_i_type_i,
  input  logic       is_s_type_i,
  input  logic       is_b_type_i,
  input  logic       is_u_type_i,
  input  logic       is_j_type_i,
  input  logic [2:0] instr_funct3_i,
  input  logic       instr_funct7_bit5_i,
  input  logic [6:0] instr_opcode_i,
  output control_t   ctrl_o
);

  control_t w_c;
  logic     w_ok;

  always_comb begin
    w_c = '0;
    w_ok = 1'b0;
    if (is_r_type_i && instr_opcode_i == OPC_R) begin
      w_ok = 1'b1;
      w_c.rf_wr_en = 1'b1;
      case ({instr_funct7_bit5_i, instr_funct3_i})
        4'b0000: w_c.alu_func = OP_ADD;
        4'b1000: w_c.alu_func = OP_SUB;
        4'b0001: w_c.alu_func = OP_SLL;
        4'b0010: w_c.alu_func = OP_SLT;
        4'b0011: w_c.alu_func = OP_SLTU;
        4'b0100: w_c.alu_func = OP_XOR;
        4'b0101: w_c.alu_func = OP_SRL;
        4'b1101: w_c.alu_func = OP_SRA;
        4'b0110: w_c.alu_func = OP_OR;
        4'b0111: w_c.alu_func = OP_AND;
        default: w_ok = 1'b0;
      endcase
    end else if (is_i_type_i && instr_opcode_i == OPC_ALUI) begin
      w_ok = 1'b1;
      w_c.op2sel = 1'b1;
      w_c.rf_wr_en = 1'b1;
      case (instr_funct3_i)
        3'b000:  w_c.alu_func = OP_ADD;
        3'b001:  w_c.alu_func = OP_SLL;
        3'b010:  w_c.alu_func = OP_SLT;
        3'b011:  w_c.alu_func = OP_SLTU;
        3'b100:  w_c.alu_func = OP_XOR;
        3'b101:  w_c.alu_func = instr_funct7_bit5_i ? OP_SRA : OP_SRL;
        3'b110:  w_c.alu_func = OP_OR;
        default: w_c.alu_func = OP_AND;
      endcase
    end else if (is_i_type_i && instr_opcode_i == OPC_LOAD) begin
      w_ok = instr_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      w_c.op2sel = 1'b1;
      w_c.data_req = 1'b1;
      w_c.rf_wr_en = 1'b1;
      w_c.rf_wr_data = RF_MEM;
      w_c.data_byte = size_of(instr_funct3_i[1:0]);
      w_c.zero_extnd = instr_funct3_i[2];
    end else if (is_i_type_i && instr_opcode_i == OPC_JALR) begin
      w_ok = instr_funct3_i == 3'b000;
      w_c.op2sel = 1'b1;
      w_c.pc_sel = 1'b1;
      w_c.rf_wr_en = 1'b1;
      w_c.rf_wr_data = RF_PC;
    end else if (is_s_type_i && instr_opcode_i == OPC_S) begin
      w_ok = instr_funct3_i inside {3'b000, 3'b001, 3'b010};
      w_c.op2sel = 1'b1;
      w_c.data_req = 1'b1;
      w_c.data_wr = 1'b1;
      w_c.data_byte = size_of(instr_funct3_i[1:0]);
    end else if (is_b_type_i && instr_opcode_i == OPC_B) begin
      w_ok = instr_funct3_i[2:1] != 2'b01;
      w_c.op1sel = 1'b1;
      w_c.op2sel = 1'b1;
    end else if (is_u_type_i && instr_opcode_i == OPC_LUI) begin
      w_ok = 1'b1;
      w_c.rf_wr_en = 1'b1;
      w_c.rf_wr_data = RF_IMM;
    end else if (is_u_type_i && instr_opcode_i == OPC_AUIPC) begin
      w_ok = 1'b1;
      w_c.op1sel = 1'b1;
      w_c.op2sel = 1'b1;
      w_c.rf_wr_en = 1'b1;
    end else if (is_j_type_i && instr_opcode_i == OPC_J) begin
      w_ok = 1'b1;
      w_c.op1sel = 1'b1;
      w_c.op2sel = 1'b1;
      w_c.pc_sel = 1'b1;
      w_c.rf_wr_en = 1'b1;
      w_c.rf_wr_data = RF_PC;
    end
    // an undecodable word carries no side effects, only the flag
    if (!w_ok) w_c = '0;
    w_c.illegal = !w_ok;
  end

  assign ctrl_o = w_c;

endmodule

// File: rtl/yarp_ctrl_pipe.sv
// yarp_ctrl_pipe: decoded control word carried through WB_STAGE stage registers with EX/MEM/WB taps.
// Flush kills both the decode slot and the word leaving EX; stall freezes every stage.
module yarp_ctrl_pipe
  import yarp_pkg::*;
#(
  parameter int MEM_STAGE = 2,
  parameter int WB_STAGE  = 3,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid_i,
  input  logic             is_r_type_i,
  input  logic             is_i_type_i,
  input  logic             is_s_type_i,
  input  logic             is_b_type_i,
  input  logic             is_u_type_i,
  input  logic             is_j_type_i,
  input  logic [2:0]       instr_funct3_i,
  input  logic             instr_funct7_bit5_i,
  input  logic [6:0]       instr_opcode_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             ex_valid_o,
  output logic             op1sel_o,
  output logic             op2sel_o,
  output logic [3:0]       alu_func_o,
  output logic             pc_sel_o,
  output logic             data_req_o,
  output logic             data_wr_o,
  output logic [1:0]       data_byte_o,
  output logic             zero_extnd_o,
  output logic [1:0]       rf_wr_data_o,
  output logic             rf_wr_en_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);

  control_t         w_dec;
  control_t         w_tap [0:WB_STAGE];
  logic             w_adv;
  logic [CNT_W-1:0] r_instret;

  yarp_ctrl_decode u_decode (
    .is_r_type_i        (is_r_type_i),
    .is_i_type_i        (is_i_type_i),
    .is_s_type_i        (is_s_type_i),
    .is_b_type_i        (is_b_type_i),
    .is_u_type_i        (is_u_type_i),
    .is_j_type_i        (is_j_type_i),
    .instr_funct3_i     (instr_funct3_i),
    .instr_funct7_bit5_i(instr_funct7_bit5_i),
    .instr_opcode_i     (instr_opcode_i),
    .ctrl_o             (w_dec)
  );

  assign w_adv = !stall_i || flush_i;

  always_comb begin
    w_tap[0] = '0;
    if (id_valid_i && !flush_i) begin
      w_tap[0] = w_dec;
      w_tap[0].valid = 1'b1;
    end
  end

  for (genvar k = 1; k <= WB_STAGE; k++) begin : g_st
    control_t r_q;
    always_ff @(posedge clk)
      if (!reset_n) r_q <= '0;
      else if (w_adv) r_q <= (k == 2 && flush_i) ? '0 : w_tap[k-1];
    assign w_tap[k] = r_q;
  end

  always_ff @(posedge clk)
    if (!reset_n) r_instret <= '0;
    else if (w_adv && w_tap[WB_STAGE].valid && !w_tap[WB_STAGE].illegal) r_instret <= r_instret + 1'b1;

  assign ex_valid_o   = w_tap[1].valid;
  assign op1sel_o     = w_tap[1].op1sel;
  assign op2sel_o     = w_tap[1].op2sel;
  assign alu_func_o   = w_tap[1].alu_func;
  assign pc_sel_o     = w_tap[1].pc_sel && w_tap[1].valid;
  assign illegal_o    = w_tap[1].illegal;
  assign data_req_o   = w_tap[MEM_STAGE].data_req && w_tap[MEM_STAGE].valid;
  assign data_wr_o    = w_tap[MEM_STAGE].data_wr && w_tap[MEM_STAGE].valid;
  assign data_byte_o  = w_tap[MEM_STAGE].data_byte;
  assign zero_extnd_o = w_tap[MEM_STAGE].zero_extnd;
  assign rf_wr_data_o = w_tap[WB_STAGE].rf_wr_data;
  assign rf_wr_en_o   = w_tap[WB_STAGE].rf_wr_en && w_tap[WB_STAGE].valid;
  assign instret_o    = r_instret;

endmodule

// File: tb/tb_yarp_ctrl_pipe.sv
// tb_yarp_ctrl_pipe: queue-scoreboard bench driving a default build and a MEM=3/WB=5/CNT_W=4 build in lockstep.
module tb_yarp_ctrl_pipe;
  import yarp_pkg::*;

  localparam int MA = 2, WA = 3, MB = 3, WB = 5;

  typedef struct packed {
    bit v, ill, o1, o2, pcs, req, wr, zx, wen;
    bit [3:0] alu;
    bit [1:0] sz, src;
  } exp_t;

  logic clk = 0, reset_n = 0, id_valid = 0, stall = 0, flush = 0;
  logic is_r = 0, is_i = 0, is_s = 0, is_b = 0, is_u = 0, is_j = 0;
  logic [2:0] f3 = 0;
  logic f7 = 0;
  logic [6:0] opc = 0;

  logic ex_valid_a, op1_a, op2_a, pcs_a, req_a, wr_a, zx_a, wen_a, ill_a;
  logic [3:0] alu_a;
  logic [1:0] byte_a, src_a;
  logic [31:0] cnt_a;
  logic ex_valid_b, op1_b, op2_b, pcs_b, req_b, wr_b, zx_b, wen_b, ill_b;
  logic [3:0] alu_b;
  logic [1:0] byte_b, src_b;
  logic [3:0] cnt_b;

  exp_t qa[$], qb[$];
  int ca = 0, cb = 0, vec = 0, err = 0;

  string legal[12] = '{"ADD", "SUB", "AND", "ADDI", "SRAI", "LW", "LBU", "JALR", "SW", "BEQ", "LUI", "JAL"};
  string every[15] = '{"ADD", "SUB", "AND", "ADDI", "SRAI", "LW", "LBU", "JALR", "SW", "BEQ", "LUI", "JAL",
                       "AUIPC", "SB_BAD", "NOTYPE"};

  always #5 clk = ~clk;

  yarp_ctrl_pipe #(.MEM_STAGE(MA), .WB_STAGE(WA), .CNT_W(32)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_valid_i(id_valid),
    .is_r_type_i(is_r), .is_i_type_i(is_i), .is_s_type_i(is_s),
    .is_b_type_i(is_b), .is_u_type_i(is_u), .is_j_type_i(is_j),
    .instr_funct3_i(f3), .instr_funct7_bit5_i(f7), .instr_opcode_i(opc),
    .stall_i(stall), .flush_i(flush),
    .ex_valid_o(ex_valid_a), .op1sel_o(op1_a), .op2sel_o(op2_a), .alu_func_o(alu_a),
    .pc_sel_o(pcs_a), .data_req_o(req_a), .data_wr_o(wr_a), .data_byte_o(byte_a),
    .zero_extnd_o(zx_a), .rf_wr_data_o(src_a), .rf_wr_en_o(wen_a), .illegal_o(ill_a),
    .instret_o(cnt_a)
  );

  yarp_ctrl_pipe #(.MEM_STAGE(MB), .WB_STAGE(WB), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_valid_i(id_valid),
    .is_r_type_i(is_r), .is_i_type_i(is_i), .is_s_type_i(is_s),
    .is_b_type_i(is_b), .is_u_type_i(is_u), .is_j_type_i(is_j),
    .instr_funct3_i(f3), .instr_funct7_bit5_i(f7), .instr_opcode_i(opc),
    .stall_i(stall), .flush_i(flush),
    .ex_valid_o(ex_valid_b), .op1sel_o(op1_b), .op2sel_o(op2_b), .alu_func_o(alu_b),
    .pc_sel_o(pcs_b), .data_req_o(req_b), .data_wr_o(wr_b), .data_byte_o(byte_b),
    .zero_extnd_o(zx_b), .rf_wr_data_o(src_b), .rf_wr_en_o(wen_b), .illegal_o(ill_b),
    .instret_o(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    vec++;
    if (act !== want) begin
      err++;
      $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, act, want);
    end
  endtask

  function automatic void clr();
    qa.delete();
    qb.delete();
    for (int i = 0; i < WA; i++) qa.push_back('0);
    for (int i = 0; i < WB; i++) qb.push_back('0);
    ca = 0;
    cb = 0;
  endfunction

  // drives the instruction fields and returns the hand-derived control word
  task automatic set_instr(input string nm, output exp_t e);
    logic [5:0] t;
    t = '0;
    f3 = 0;
    f7 = 0;
    e = '0;
    e.v = 1;
    e.alu = OP_ADD;
    case (nm)
      "ADD":    begin t = 6'b100000; opc = 7'h33; e.wen = 1; end
      "SUB":    begin t = 6'b100000; opc = 7'h33; f7 = 1; e.alu = OP_SUB; e.wen = 1; end
      "AND":    begin t = 6'b100000; opc = 7'h33; f3 = 7; e.alu = OP_AND; e.wen = 1; end
      "ADDI":   begin t = 6'b010000; opc = 7'h13; e.o2 = 1; e.wen = 1; end
      "SRAI":   begin t = 6'b010000; opc = 7'h13; f3 = 5; f7 = 1; e.o2 = 1; e.alu = OP_SRA; e.wen = 1; end
      "LW":     begin t = 6'b010000; opc = 7'h03; f3 = 2; e.o2 = 1; e.req = 1; e.wen = 1; e.src = RF_MEM; e.sz = WORD; end
      "LBU":    begin t = 6'b010000; opc = 7'h03; f3 = 4; e.o2 = 1; e.req = 1; e.wen = 1; e.src = RF_MEM; e.sz = BYTE; e.zx = 1; end
      "JALR":   begin t = 6'b010000; opc = 7'h67; e.o2 = 1; e.pcs = 1; e.wen = 1; e.src = RF_PC; end
      "SW":     begin t = 6'b001000; opc = 7'h23; f3 = 2; e.o2 = 1; e.req = 1; e.wr = 1; e.sz = WORD; end
      "SB_BAD": begin t = 6'b001000; opc = 7'h23; f3 = 3; e = '0; e.v = 1; e.ill = 1; end
      "BEQ":    begin t = 6'b000100; opc = 7'h63; e.o1 = 1; e.o2 = 1; end
      "LUI":    begin t = 6'b000010; opc = 7'h37; e.wen = 1; e.src = RF_IMM; end
      "AUIPC":  begin t = 6'b000010; opc = 7'h17; e.o1 = 1; e.o2 = 1; e.wen = 1; end
      "JAL":    begin t = 6'b000001; opc = 7'h6F; e.o1 = 1; e.o2 = 1; e.pcs = 1; e.wen = 1; e.src = RF_PC; end
      default:  begin t = 6'b000000; opc = 7'h33; e = '0; e.v = 1; e.ill = 1; end
    endcase
    {is_r, is_i, is_s, is_b, is_u, is_j} = t;
  endtask

  task automatic check_all();
    check("ex_valid_a", ex_valid_a, qa[0].v);
    check("op1sel_a", op1_a, qa[0].o1);
    check("op2sel_a", op2_a, qa[0].o2);
    check("alu_func_a", alu_a, qa[0].alu);
    check("pc_sel_a", pcs_a, qa[0].pcs);
    check("illegal_a", ill_a, qa[0].ill);
    check("data_req_a", req_a, qa[MA-1].req);
    check("data_wr_a", wr_a, qa[MA-1].wr);
    check("data_byte_a", byte_a, qa[MA-1].sz);
    check("zero_extnd_a", zx_a, qa[MA-1].zx);
    check("rf_wr_data_a", src_a, qa[WA-1].src);
    check("rf_wr_en_a", wen_a, qa[WA-1].wen);
    check("instret_a", cnt_a, ca);
    check("ex_valid_b", ex_valid_b, qb[0].v);
    check("op1sel_b", op1_b, qb[0].o1);
    check("op2sel_b", op2_b, qb[0].o2);
    check("alu_func_b", alu_b, qb[0].alu);
    check("pc_sel_b", pcs_b, qb[0].pcs);
    check("illegal_b", ill_b, qb[0].ill);
    check("data_req_b", req_b, qb[MB-1].req);
    check("data_wr_b", wr_b, qb[MB-1].wr);
    check("data_byte_b", byte_b, qb[MB-1].sz);
    check("zero_extnd_b", zx_b, qb[MB-1].zx);
    check("rf_wr_data_b", src_b, qb[WB-1].src);
    check("rf_wr_en_b", wen_b, qb[WB-1].wen);
    check("instret_b", cnt_b, cb);
  endtask

  // one clock: drive, let the edge happen, advance the scoreboard queues, compare
  task automatic cyc(input string nm, input bit st, input bit fl);
    exp_t e, o;
    e = '0;
    if (nm == "") begin
      id_valid = 0;
      {is_r, is_i, is_s, is_b, is_u, is_j} = 6'($urandom);
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      opc = 7'($urandom);
    end else begin
      set_instr(nm, e);
      id_valid = 1;
    end
    stall = st;
    flush = fl;
    @(posedge clk);
    if (!reset_n) clr();
    else if (!st || fl) begin
      if (fl) e = '0;
      qa.push_front(e);
      o = qa.pop_back();
      if (o.v && !o.ill) ca++;
      if (fl) qa[1] = '0;
      qb.push_front(e);
      o = qb.pop_back();
      if (o.v && !o.ill) cb = (cb + 1) % 16;
      if (fl) qb[1] = '0;
    end
    #1;
    check_all();
  endtask

  initial begin
    clr();
    reset_n = 0;
    cyc("JAL", 1, 0);
    cyc("ADD", 0, 1);
    reset_n = 1;
    repeat (3) cyc("", 0, 0);
    cyc("ADD", 0, 0);
    cyc("LW", 0, 0);
    cyc("SW", 0, 0);
    cyc("JAL", 0, 0);
    repeat (6) cyc("", 0, 0);
    check("instret_a_prog", cnt_a, 4);
    check("instret_b_prog", cnt_b, 4);
    cyc("SUB", 0, 0);
    cyc("LBU", 0, 0);
    repeat (3) cyc("ADDI", 1, 0);
    cyc("ADDI", 0, 0);
    cyc("SRAI", 0, 0);
    repeat (6) cyc("", 0, 0);
    cyc("LW", 0, 0);
    cyc("BEQ", 0, 0);
    cyc("ADD", 1, 1);
    cyc("LW", 0, 0);
    cyc("AND", 0, 0);
    cyc("SUB", 1, 1);
    repeat (6) cyc("", 0, 0);
    cyc("SB_BAD", 0, 0);
    cyc("NOTYPE", 0, 0);
    cyc("SW", 0, 0);
    cyc("LUI", 0, 0);
    cyc("AUIPC", 0, 0);
    cyc("JALR", 0, 0);
    cyc("BEQ", 1, 0);
    cyc("BEQ", 0, 0);
    repeat (6) cyc("", 0, 0);
    for (int i = 0; i < 80; i++)
      cyc($urandom_range(4, 0) == 0 ? "" : every[$urandom_range(14, 0)],
          $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0);
    cyc("ADD", 0, 0);
    cyc("LW", 0, 0);
    reset_n = 0;
    cyc("SW", 1, 1);
    reset_n = 1;
    for (int i = 0; i < 17; i++) cyc(legal[$urandom_range(11, 0)], 0, 0);
    repeat (6) cyc("", 0, 0);
    check("instret_a_17", cnt_a, 17);
    check("instret_b_wrap", cnt_b, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
